// File: rtl/uart8.sv
// uart8 - 8-N-1 UART, independent receiver and transmitter on one clock.
//
// The receiver oversamples the line with a free-running 16x baud tick and
// samples each bit at its middle. The transmitter holds each bit for one
// full baud period counted in system clocks.
//
// Parameters:
//   CLOCK_RATE  system clock frequency in Hz
//   BAUD_RATE   serial bit rate
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous active-high reset
//   rxEn     receiver enable; low holds the receiver idle
//   rxIn     serial input line (idle high)
//   rxBusy   high while a frame is being received
//   rxDone   one-cycle pulse, valid byte on rxOut
//   rxErr    one-cycle pulse, framing error (stop bit low)
//   rxOut    last valid received byte
//   txEn     transmitter enable; low holds the transmitter idle
//   txStart  send request, accepted only when idle
//   txIn     byte to send, latched on acceptance
//   txBusy   high while a frame is being sent
//   txDone   one-cycle pulse at the end of the stop bit
//   txOut    serial output line (idle high), registered
module uart8 #(
  parameter int CLOCK_RATE = 100000000,
  parameter int BAUD_RATE  = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxEn,
  input  logic       rxIn,
  output logic       rxBusy,
  output logic       rxDone,
  output logic       rxErr,
  output logic [7:0] rxOut,
  input  logic       txEn,
  input  logic       txStart,
  input  logic [7:0] txIn,
  output logic       txBusy,
  output logic       txDone,
  output logic       txOut
);

  localparam int RX_DIV = CLOCK_RATE / (BAUD_RATE * 16);
  localparam int TX_DIV = CLOCK_RATE / BAUD_RATE;
  localparam int RX_W   = (RX_DIV > 1) ? $clog2(RX_DIV) : 1;
  localparam int TX_W   = (TX_DIV > 1) ? $clog2(TX_DIV) : 1;
  localparam logic [RX_W-1:0] RX_LAST = RX_W'(RX_DIV - 1);
  localparam logic [TX_W-1:0] TX_LAST = TX_W'(TX_DIV - 1);

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_state_t;

  // ---------------- receiver ----------------
  logic [RX_W-1:0] rx_div_cnt;
  logic            rx_tick;
  logic            rx_s1, rx_s2;
  rx_state_t       rx_state, rx_state_n;
  logic [3:0]      rx_tick_cnt, rx_tick_n;
  logic [2:0]      rx_bit_cnt, rx_bit_n;
  logic [7:0]      rx_sh, rx_sh_n, rx_out_n;
  logic            rx_done_n, rx_err_n;

  // Free-running 16x tick; not aligned to the start edge, so the bit-middle
  // sample lands within one tick of the true centre.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    rx_div_cnt <= '0;
    else if (rx_div_cnt == RX_LAST) rx_div_cnt <= '0;
    else                          rx_div_cnt <= rx_div_cnt + RX_W'(1);
  end

  assign rx_tick = (rx_div_cnt == RX_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1       <= 1'b1;
      rx_s2       <= 1'b1;
      rx_state    <= RX_IDLE;
      rx_tick_cnt <= '0;
      rx_bit_cnt  <= '0;
      rx_sh       <= '0;
      rxOut       <= '0;
      rxDone      <= 1'b0;
      rxErr       <= 1'b0;
    end else begin
      rx_s1       <= rxIn;
      rx_s2       <= rx_s1;
      rx_state    <= rx_state_n;
      rx_tick_cnt <= rx_tick_n;
      rx_bit_cnt  <= rx_bit_n;
      rx_sh       <= rx_sh_n;
      rxOut       <= rx_out_n;
      rxDone      <= rx_done_n;
      rxErr       <= rx_err_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_tick_n  = rx_tick_cnt;
    rx_bit_n   = rx_bit_cnt;
    rx_sh_n    = rx_sh;
    rx_out_n   = rxOut;
    rx_done_n  = 1'b0;
    rx_err_n   = 1'b0;
    if (!rxEn) begin
      rx_state_n = RX_IDLE;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (!rx_s2) begin
            rx_state_n = RX_START;
            rx_tick_n  = '0;
          end
        end
        RX_START: begin
          if (rx_tick) begin
            if (rx_tick_cnt == 4'd7) begin
              // Line back high at the start-bit middle: false start.
              if (rx_s2) begin
                rx_state_n = RX_IDLE;
              end else begin
                rx_state_n = RX_DATA;
                rx_tick_n  = '0;
                rx_bit_n   = '0;
              end
            end else begin
              rx_tick_n = rx_tick_cnt + 4'd1;
            end
          end
        end
        RX_DATA: begin
          if (rx_tick) begin
            if (rx_tick_cnt == 4'd15) begin
              rx_tick_n = '0;
              rx_sh_n   = {rx_s2, rx_sh[7:1]};
              if (rx_bit_cnt == 3'd7) rx_state_n = RX_STOP;
              else                    rx_bit_n   = rx_bit_cnt + 3'd1;
            end else begin
              rx_tick_n = rx_tick_cnt + 4'd1;
            end
          end
        end
        RX_STOP: begin
          if (rx_tick) begin
            if (rx_tick_cnt == 4'd15) begin
              rx_tick_n = '0;
              if (rx_s2) begin
                rx_out_n   = rx_sh;
                rx_done_n  = 1'b1;
                rx_state_n = RX_IDLE;
              end else begin
                rx_err_n   = 1'b1;
                rx_state_n = RX_WAIT_HIGH;
              end
            end else begin
              rx_tick_n = rx_tick_cnt + 4'd1;
            end
          end
        end
        RX_WAIT_HIGH: begin
          // A held-low (break) line must not be taken as a new start bit.
          if (rx_s2) rx_state_n = RX_IDLE;
        end
        default: rx_state_n = RX_IDLE;
      endcase
    end
  end

  assign rxBusy = (rx_state == RX_START) || (rx_state == RX_DATA) ||
                  (rx_state == RX_STOP);

  // ---------------- transmitter ----------------
  tx_state_t       tx_state, tx_state_n;
  logic [TX_W-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]      tx_bit_cnt, tx_bit_n;
  logic [7:0]      tx_sh, tx_sh_n;
  logic            tx_out_n, tx_done_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state   <= TX_IDLE;
      tx_cnt     <= '0;
      tx_bit_cnt <= '0;
      tx_sh      <= '0;
      txOut      <= 1'b1;
      txDone     <= 1'b0;
    end else begin
      tx_state   <= tx_state_n;
      tx_cnt     <= tx_cnt_n;
      tx_bit_cnt <= tx_bit_n;
      tx_sh      <= tx_sh_n;
      txOut      <= tx_out_n;
      txDone     <= tx_done_n;
    end
  end

  // txOut is loaded with the level of the state being entered, so the line
  // changes on the same edge as the state and each level lasts TX_DIV clocks.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit_cnt;
    tx_sh_n    = tx_sh;
    tx_out_n   = txOut;
    tx_done_n  = 1'b0;
    if (!txEn) begin
      tx_state_n = TX_IDLE;
      tx_out_n   = 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          tx_out_n = 1'b1;
          if (txStart) begin
            tx_state_n = TX_START;
            tx_sh_n    = txIn;
            tx_cnt_n   = '0;
            tx_out_n   = 1'b0;
          end
        end
        TX_START: begin
          if (tx_cnt == TX_LAST) begin
            tx_state_n = TX_DATA;
            tx_cnt_n   = '0;
            tx_bit_n   = '0;
            tx_out_n   = tx_sh[0];
          end else begin
            tx_cnt_n = tx_cnt + TX_W'(1);
          end
        end
        TX_DATA: begin
          if (tx_cnt == TX_LAST) begin
            tx_cnt_n = '0;
            if (tx_bit_cnt == 3'd7) begin
              tx_state_n = TX_STOP;
              tx_out_n   = 1'b1;
            end else begin
              tx_bit_n = tx_bit_cnt + 3'd1;
              tx_sh_n  = {1'b0, tx_sh[7:1]};
              tx_out_n = tx_sh[1];
            end
          end else begin
            tx_cnt_n = tx_cnt + TX_W'(1);
          end
        end
        TX_STOP: begin
          if (tx_cnt == TX_LAST) begin
            tx_state_n = TX_IDLE;
            tx_cnt_n   = '0;
            tx_done_n  = 1'b1;
            tx_out_n   = 1'b1;
          end else begin
            tx_cnt_n = tx_cnt + TX_W'(1);
          end
        end
        default: begin
          tx_state_n = TX_IDLE;
          tx_out_n   = 1'b1;
        end
      endcase
    end
  end

  assign txBusy = (tx_state != TX_IDLE);

endmodule

// File: tb/tb_uart8.sv
// tb_uart8 - self-checking bench for uart8.
// Expected receive results and transmit frames are queued by the stimulus;
// two monitor processes compare them against what the DUT presents.
`timescale 1ns/1ps
module tb_uart8;

  localparam int CLK_HZ = 1536000;
  localparam int BAUD   = 9600;
  localparam int T      = CLK_HZ / BAUD;   // clocks per bit (160)

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rxEn = 1'b1;
  logic       txEn = 1'b1;
  logic       txStart = 1'b0;
  logic [7:0] txIn = 8'h00;
  logic       rx_drv = 1'b1;
  logic       loop = 1'b0;
  logic       rx_abort = 1'b0;
  logic       rx_line;
  logic       rxBusy, rxDone, rxErr, txBusy, txDone, txOut;
  logic [7:0] rxOut;

  assign rx_line = loop ? txOut : rx_drv;

  uart8 #(.CLOCK_RATE(CLK_HZ), .BAUD_RATE(BAUD)) dut (
    .clk(clk), .reset(reset),
    .rxEn(rxEn), .rxIn(rx_line), .rxBusy(rxBusy), .rxDone(rxDone),
    .rxErr(rxErr), .rxOut(rxOut),
    .txEn(txEn), .txStart(txStart), .txIn(txIn), .txBusy(txBusy),
    .txDone(txDone), .txOut(txOut)
  );

  initial forever #5 clk = ~clk;

  typedef struct { bit err; logic [7:0] data; } rx_exp_t;
  rx_exp_t    rxq[$];
  logic [7:0] txq[$];
  logic [7:0] last_good = 8'h00;
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_rx(input bit err, input logic [7:0] d);
    rx_exp_t e;
    e.err = err;
    e.data = d;
    rxq.push_back(e);
  endtask

  // ---------------- receive monitor ----------------
  initial begin : rx_mon
    rx_exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && (rxDone || rxErr)) begin
        check("rx_pulse_exclusive", 32'(rxDone & rxErr), 32'd0);
        if (rxq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rx_unexpected: done=%0b err=%0b rxOut=%0h want no pulse (t=%0t)",
                   rxDone, rxErr, rxOut, $time);
        end else begin
          e = rxq.pop_front();
          check("rx_kind_err", 32'(rxErr), 32'(e.err));
          if (!e.err) begin
            check("rx_data", 32'(rxOut), 32'(e.data));
            last_good = e.data;
          end else begin
            check("rx_out_hold_on_err", 32'(rxOut), 32'(last_good));
          end
        end
      end
    end
  end

  // ---------------- transmit monitor ----------------
  initial begin : tx_mon
    int tcnt;
    int ph;
    bit tact;
    logic [9:0] fexp;
    tcnt = 0;
    tact = 0;
    fexp = '1;
    forever begin
      @(negedge clk);
      if (reset) begin
        tact = 0;
      end else begin
        if (tact) begin
          tcnt++;
        end else if (txOut == 1'b0) begin
          tact = 1;
          tcnt = 0;
          if (txq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL tx_unexpected_frame: start bit seen, want none (t=%0t)", $time);
            fexp = '1;
          end else begin
            fexp = {1'b1, txq.pop_front(), 1'b0};
          end
          check("tx_busy_in_frame", 32'(txBusy), 32'd1);
        end else if (txDone) begin
          total++;
          bad++;
          $display("FAIL tx_unexpected_done: txDone=1 want 0 (t=%0t)", $time);
        end
        if (tact) begin
          if (tcnt < 10 * T) begin
            ph = tcnt % T;
            if (ph == 0 || ph == T / 2 || ph == T - 1)
              check("tx_bit_level", 32'(txOut), 32'(fexp[tcnt / T]));
            if (txDone) begin
              check("tx_done_time", 32'(tcnt), 32'(10 * T));
              tact = 0;
            end
          end else begin
            check("tx_done_at_10T", 32'(txDone), 32'd1);
            check("tx_busy_after", 32'(txBusy), 32'd0);
            tact = 0;
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_rx(input logic [7:0] d, input int bt, input int stop_len);
    logic [9:0] fr;
    fr = {1'b1, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = fr[i];
      for (int c = 0; c < ((i == 9) ? stop_len : bt); c++) begin
        @(negedge clk);
        if (rx_abort) begin
          rx_drv = 1'b1;
          return;
        end
      end
    end
  endtask

  task automatic tx_go(input logic [7:0] d);
    for (int i = 0; i < 12 * T && txBusy; i++) @(negedge clk);
    check("tx_idle_before_start", 32'(txBusy), 32'd0);
    @(negedge clk);
    txIn = d;
    txStart = 1'b1;
    txq.push_back(d);
    @(negedge clk);
    txStart = 1'b0;
  endtask

  task automatic wait_tx_done();
    bit seen;
    seen = 0;
    for (int i = 0; i < 12 * T && !seen; i++) begin
      @(negedge clk);
      if (txDone) seen = 1;
    end
    check("tx_done_seen", 32'(seen), 32'd1);
  endtask

  task automatic wait_rx_drain();
    for (int i = 0; i < 4 * T && rxq.size() != 0; i++) @(negedge clk);
    check("rx_drain", 32'(rxq.size()), 32'd0);
  endtask

  task automatic check_reset_values();
    check("rst_rxBusy", 32'(rxBusy), 32'd0);
    check("rst_rxDone", 32'(rxDone), 32'd0);
    check("rst_rxErr",  32'(rxErr),  32'd0);
    check("rst_rxOut",  32'(rxOut),  32'd0);
    check("rst_txBusy", 32'(txBusy), 32'd0);
    check("rst_txDone", 32'(txDone), 32'd0);
    check("rst_txOut",  32'(txOut),  32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin : stim
    logic [7:0] d;
    logic [7:0] lb[$];
    int bt;
    bit seen;

    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values();
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // 0x56 with bits ~3% long
    push_rx(1'b0, 8'h56);
    send_rx(8'h56, 165, 165);
    repeat (20) @(negedge clk);
    wait_rx_drain();

    // Short low glitch: brief busy, no pulse, rxOut kept
    seen = 0;
    rx_drv = 1'b0;
    repeat (25) begin
      @(negedge clk);
      seen |= rxBusy;
    end
    rx_drv = 1'b1;
    repeat (100) @(negedge clk);
    check("glitch_busy_seen", 32'(seen), 32'd1);
    check("glitch_busy_clear", 32'(rxBusy), 32'd0);
    check("glitch_rxout_hold", 32'(rxOut), 32'(last_good));

    // Stop bit cut short then line held low: one error, then wait for high
    push_rx(1'b1, 8'h00);
    send_rx(8'h56, T, 40);
    rx_drv = 1'b0;
    repeat (20 * T) @(negedge clk);
    check("break_not_busy", 32'(rxBusy), 32'd0);
    check("break_rxout_hold", 32'(rxOut), 32'h56);
    rx_drv = 1'b1;
    repeat (100) @(negedge clk);
    push_rx(1'b0, 8'hC3);
    send_rx(8'hC3, T, T);
    wait_rx_drain();

    // Transmit 0x56; a second request mid-frame must be ignored
    tx_go(8'h56);
    repeat (4 * T) @(negedge clk);
    txIn = 8'hAA;
    txStart = 1'b1;
    @(negedge clk);
    txStart = 1'b0;
    wait_tx_done();
    repeat (10) @(negedge clk);

    // Loopback
    lb = '{8'h00, 8'hFF, 8'hA5};
    repeat (3) lb.push_back(8'($urandom));
    loop = 1'b1;
    foreach (lb[i]) begin
      push_rx(1'b0, lb[i]);
      tx_go(lb[i]);
      wait_tx_done();
      wait_rx_drain();
    end
    loop = 1'b0;
    repeat (20) @(negedge clk);

    // Random bytes at randomized bit periods within about +-3%
    for (int k = 0; k < 6; k++) begin
      d = 8'($urandom);
      bt = int'($urandom_range(T + 5, T - 5));
      push_rx(1'b0, d);
      send_rx(d, bt, bt);
      repeat (int'($urandom_range(60, 20))) @(negedge clk);
      wait_rx_drain();
    end

    // Reset in the middle of both an rx and a tx frame
    tx_go(8'h3C);
    push_rx(1'b0, 8'h99);
    fork
      send_rx(8'h99, T, T);
    join_none
    repeat (700) @(negedge clk);
    check("mid_rxBusy", 32'(rxBusy), 32'd1);
    check("mid_txBusy", 32'(txBusy), 32'd1);
    #2 reset = 1'b1;
    rx_abort = 1'b1;
    rxq.delete();
    txq.delete();
    last_good = 8'h00;
    #1;
    check_reset_values();
    repeat (3) @(negedge clk);
    rx_abort = 1'b0;
    rx_drv = 1'b1;
    reset = 1'b0;
    repeat (10) @(negedge clk);

    push_rx(1'b0, 8'h5A);
    send_rx(8'h5A, T, T);
    wait_rx_drain();
    loop = 1'b1;
    push_rx(1'b0, 8'hE7);
    tx_go(8'hE7);
    wait_tx_done();
    wait_rx_drain();
    loop = 1'b0;
    repeat (20) @(negedge clk);

    check("final_rxq_empty", 32'(rxq.size()), 32'd0);
    check("final_txq_empty", 32'(txq.size()), 32'd0);
    check("final_rxOut", 32'(rxOut), 32'(last_good));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart8.md
# uart8

8-N-1 UART with independent receiver and transmitter sharing one system clock and one baud-rate generator. It sits between a board-level serial pin pair and the byte-level logic of the design. The block converts one asynchronous serial frame to a parallel byte, and the reverse. The receiver oversamples at 16x baud to tolerate roughly ±3% transmitter clock mismatch.

## Interface
Parameters:
- CLOCK_RATE, 100000000: system clock frequency in Hz.
- BAUD_RATE, 9600: serial bit rate.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- rxEn  in  1  receiver enable. Low holds the receiver in IDLE.
- rxIn  in  1  serial input line; idle level is high.
- rxBusy  out  1  high while a frame is being received.
- rxDone  out  1  one-cycle pulse when a valid byte is on rxOut.
- rxErr  out  1  one-cycle pulse on a framing error (stop bit low).
- rxOut  out  8  last valid received byte.
- txEn  in  1  transmitter enable. Low holds the transmitter in IDLE.
- txStart  in  1  request to send txIn; only accepted in IDLE.
- txIn  in  8  byte to send; latched when txStart is accepted.
- txBusy  out  1  high while a frame is being sent.
- txDone  out  1  one-cycle pulse when the stop bit has finished.
- txOut  out  1  serial output line; idle level is high.

## Operation
Baud generation:
- RX_DIV = CLOCK_RATE/(BAUD_RATE*16) and TX_DIV = CLOCK_RATE/BAUD_RATE, both using integer division. For 12 MHz at 9600 baud these are 78 and 1250.
- Counter widths are $clog2 of the divisor.
- The rx tick is a free-running one-cycle strobe every RX_DIV clocks.
- The tx bit counter restarts at frame start.

Receiver:
- rxIn passes through a 2-flop synchronizer before use.
- IDLE: wait for the synchronized line to be low while rxEn=1. Then go to START and set rxBusy.
- START: count 8 rx ticks to reach the bit middle. If the line is high there, it is a false start: go to IDLE with no pulse. Otherwise clear the tick count and go to DATA.
- DATA: sample every 16 ticks. Bits shift in LSB first. After the 8th bit go to STOP.
- STOP: sample after 16 ticks.
  - Line high: rxOut ← shift register, pulse rxDone, go to IDLE.
  - Line low: pulse rxErr, leave rxOut unchanged, go to WAIT_HIGH.
- WAIT_HIGH: stay until the line is high, then go to IDLE. A held-low line (break) is therefore never read as a new start.
- rxBusy is high in START, DATA and STOP only.
- rxEn going low in any state forces IDLE on the next clock. No pulses are issued in that case.

Transmitter:
- IDLE: txOut=1. When txEn=1 and txStart=1, latch txIn and go to START.
- Each following state lasts TX_DIV clocks:
  - START: txOut=0.
  - DATA: 8 bits, LSB first.
  - STOP: txOut=1.
- After STOP, pulse txDone and return to IDLE.
- txStart is ignored while txBusy=1. It is accepted again on the cycle after txDone.
- txBusy is high from the clock after acceptance through the end of STOP.
- txEn low forces IDLE and txOut=1.

## Timing
- Reset values: rxBusy=0, rxDone=0, rxErr=0, rxOut=8'h00, txBusy=0, txDone=0, txOut=1. All FSMs go to IDLE, and all counters, shift registers and synchronizer flops are cleared to the idle line level (synchronizer to 1).
- Reset asserted mid-frame aborts the frame with no pulse.
- Rx latency: rxDone rises 2 synchronizer cycles plus about 8+16*9 rx ticks after the start-bit falling edge. That is the stop-bit middle.
- rxOut updates on the same cycle as the rxDone rise and holds until the next valid frame.
- rxDone and rxErr are mutually exclusive, each exactly one clock wide.
- A start glitch shorter than 8 rx ticks (half a bit) produces only a brief rxBusy and no pulse.
- Tx frame length is exactly 10*TX_DIV clocks from the first START cycle to the txDone pulse.
- txOut is registered and glitch-free.

## Test plan
- 12 MHz, 9600 baud, rxIn sends 0x56 at a 107.5 µs bit period (3% slow) with a valid stop bit. Required: one rxDone pulse, rxOut=8'h56, rxErr never high.
- rxIn low for 16 µs, then high. Required: rxBusy rises, then falls by the start midpoint. No rxDone, no rxErr, and rxOut keeps its previous value.
- Frame 0x56 whose stop bit lasts only 55 µs before the line goes low again. Required: rxErr pulses once, no rxDone, rxOut unchanged, and the receiver waits in WAIT_HIGH until rxIn returns high.
- txStart with txIn=8'h56. Required: txOut sequence 0,0,1,1,0,1,0,1,0,1, each level held 1250 clocks. Then a txDone pulse. A second txStart during the frame is ignored.
- Loopback txOut→rxIn over bytes 0x00, 0xFF, 0xA5. Required: each is received with rxDone and a matching rxOut.
- Reset pulse in the middle of an rx frame and a tx frame. Required: all outputs return to their reset values immediately. The next full frame is received correctly.
